store_issue_queue: RTL and testbench

//  Parametrised successor of the S-type store decoder.
//  - Decodes S-type stores (funct3 -> SB/SH/SW/SD), forms effective address rs1_data+sext(imm),

---
 rtl/store_pkg.sv | 38 +++
 rtl/store_decode_align.sv | 82 ++++++++
 rtl/store_issue_queue.sv | 111 +++++++++++
 tb/tb_store_issue_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types for the store issue path: store kinds, funct3 codes, queue entry.
// Entries are sized for the widest XLEN; narrower builds use the low bits.
package store_pkg;

  typedef enum logic [2:0] {
    STR_NOP,
    SB,
    SH,
    SW,
    SD
  } str_ctrl_t;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] F3_SD = 3'd3;

  localparam int XLEN_MAX = 64;

  typedef struct packed {
    logic [XLEN_MAX-1:0]   addr;
    logic [XLEN_MAX-1:0]   wdata;
    logic [XLEN_MAX/8-1:0] be;
  } store_entry_t;

  function automatic logic [3:0] str_bytes(input str_ctrl_t c);
    logic [3:0] n;
    unique case (c)
      SB:      n = 4'd1;
      SH:      n = 4'd2;
      SW:      n = 4'd4;
      SD:      n = 4'd8;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/store_decode_align.sv
// S-type decode, effective address and lane alignment of enables and data.
// STORE_MISALIGN_CHK_EN adds the misalign output.
module store_decode_align
  import store_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instruction_code,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output str_ctrl_t       ctrl,
`ifdef STORE_MISALIGN_CHK_EN
  output logic            misalign,
`endif
  output store_entry_t    entry
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  logic [2:0]      f3;
  logic [11:0]     imm;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] dmask;
  logic [XLEN-1:0] wdata;
  logic [OW-1:0]   off;
  logic [3:0]      nbytes;
  logic [NB-1:0]   be;

  assign rs1  = instruction_code[19:15];
  assign rs2  = instruction_code[24:20];
  assign f3   = instruction_code[14:12];
  assign imm  = {instruction_code[31:25],
                 instruction_code[11:7]};
  assign addr = rs1_data
              + {{(XLEN-12){imm[11]}}, imm};
  assign off  = addr[OW-1:0];

  always_comb begin
    ctrl = STR_NOP;
    unique case (1'b1)
      f3 == F3_SB: ctrl = SB;
      f3 == F3_SH: ctrl = SH;
      f3 == F3_SW: ctrl = SW;
      f3 == F3_SD && XLEN == 64:
        ctrl = SD;
      default: ctrl = STR_NOP;
    endcase
  end

  assign nbytes = str_bytes(ctrl);

  always_comb begin
    dmask = '0;
    for (int i = 0; i < NB; i++)
      dmask[8*i +: 8] =
        {8{i < 32'(nbytes)}};
  end

  // Shifts truncate at the word edge: bytes past it drop.
  assign be = NB'((16'd1 << nbytes) - 16'd1)
            << off;
  assign wdata = (rs2_data & dmask)
               << {off, 3'b000};

`ifdef STORE_MISALIGN_CHK_EN
  logic [3:0] off4;
  assign off4 = 4'(off);
  assign misalign = (ctrl != STR_NOP)
                  && |(off4 & (nbytes - 4'd1));
`endif

  always_comb begin
    entry       = '0;
    entry.addr  = XLEN_MAX'(addr);
    entry.wdata = XLEN_MAX'(wdata);
    entry.be    = (XLEN_MAX/8)'(be);
  end

endmodule

// File: rtl/store_issue_queue.sv
// In-order store buffer between execute and data memory.
// Optional STORE_MISALIGN_CHK_EN rejects misaligned stores with a fault pulse.
module store_issue_queue
  import store_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:7]                instruction_code,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  input  logic [XLEN-1:0]            rs1_data,
  input  logic [XLEN-1:0]            rs2_data,
  input  logic                       flush,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [XLEN-1:0]            mem_addr,
  output logic [XLEN-1:0]            mem_wdata,
  output logic [XLEN/8-1:0]          mem_be,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       illegal_store,
  output logic                       misalign_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW:0]  wptr, rptr;
  store_entry_t q [DEPTH];
  store_entry_t nent, head;
  str_ctrl_t    ctrl;
  logic         full, empty;
  logic         accept, bad, enq, pop;

  store_decode_align #(.XLEN(XLEN)) u_dec (
    .instruction_code (instruction_code),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .rs1              (rs1),
    .rs2              (rs2),
    .ctrl             (ctrl),
`ifdef STORE_MISALIGN_CHK_EN
    .misalign         (bad),
`endif
    .entry            (nent)
  );

`ifndef STORE_MISALIGN_CHK_EN
  assign bad = 1'b0;
`endif

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0])
              && (wptr[AW] != rptr[AW]);

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign enq      = accept && !flush
                 && (ctrl != STR_NOP) && !bad;
  assign pop      = mem_req_valid && mem_req_ready
                 && !flush;

  always_ff @(posedge clk) begin
    if (enq) q[wptr[AW-1:0]] <= nent;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_store <= 1'b0;
    else illegal_store <= accept
                       && (ctrl == STR_NOP);
  end

`ifdef STORE_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_fault <= 1'b0;
    else misalign_fault <= accept && bad;
  end
`else
  assign misalign_fault = 1'b0;
`endif

  assign count = CW'(wptr - rptr);
  assign head  = q[rptr[AW-1:0]];

  // Gate the head so payload reads zero while empty or in reset.
  assign mem_req_valid = !empty;
  assign mem_addr  = mem_req_valid
                   ? head.addr[XLEN-1:0] : '0;
  assign mem_wdata = mem_req_valid
                   ? head.wdata[XLEN-1:0] : '0;
  assign mem_be    = mem_req_valid
                   ? head.be[XLEN/8-1:0] : '0;

endmodule

// File: tb/tb_store_issue_queue.sv
// Scoreboard bench for store_issue_queue (XLEN=32, DEPTH=4).
// Expected entries queue at issue; a negedge monitor checks each handshake.
module tb_store_issue_queue;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:7] ins;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1d, rs2d;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  count;
  logic        illegal_store;
  logic        misalign_fault;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  store_issue_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .instruction_code (ins),
    .rs1              (rs1),
    .rs2              (rs2),
    .rs1_data         (rs1d),
    .rs2_data         (rs2d),
    .flush            (flush),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_be           (mem_be),
    .count            (count),
    .illegal_store    (illegal_store),
    .misalign_fault   (misalign_fault)
  );

  function automatic logic [31:7] enc(
    input logic [2:0] f3, input logic [4:0] r1,
    input logic [4:0] r2, input logic [11:0] imm);
    return {imm[11:5], r2, r1, f3, imm[4:0]};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && mem_req_valid && mem_req_ready) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_req actual=%h required=none",
                 mem_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (mem_addr !== e.a || mem_wdata !== e.d
            || mem_be !== e.b) begin
          nerr++;
          $display("FAIL drain actual=%h/%h/%h required=%h/%h/%h",
                   mem_addr, mem_wdata, mem_be, e.a, e.d, e.b);
        end
      end
    end
  end

  task automatic issue(input logic [31:7] code,
                       input logic [31:0] b,
                       input logic [31:0] d,
                       input bit q,
                       input logic [31:0] ea,
                       input logic [31:0] ed,
                       input logic [3:0] eb);
    exp_t e;
    if (q) begin
      e.a = ea; e.d = ed; e.b = eb;
      sb.push_back(e);
    end
    ins = code; rs1d = b; rs2d = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while (count != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(count), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; ins = '0; rs1d = '0; rs2d = '0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_illegal", 32'(illegal_store), 32'd0);
    chk("rst_misalign", 32'(misalign_fault), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    ins = enc(3'd2, 5'd3, 5'd7, 12'h0);
    #1;
    chk("rs1_idx", 32'(rs1), 32'd3);
    chk("rs2_idx", 32'(rs2), 32'd7);

    // SW and SB, draining immediately
    mem_req_ready = 1'b1;
    issue(enc(3'd2, 5'd1, 5'd2, 12'h004),
          32'h1000, 32'hDEADBEEF,
          1, 32'h1004, 32'hDEADBEEF, 4'hF);
    chk("sw_latency_valid", 32'(mem_req_valid), 32'd1);
    issue(enc(3'd0, 5'd1, 5'd2, 12'h003),
          32'h1000, 32'h123456AB,
          1, 32'h1003, 32'hAB000000, 4'h8);
    wait_empty("drain1");

    // Fill to full, hold, then drain with concurrent pushes
    mem_req_ready = 1'b0;
    issue(enc(3'd2, 5'd1, 5'd2, 12'h000),
          32'h2000, 32'h11111111,
          1, 32'h2000, 32'h11111111, 4'hF);
    issue(enc(3'd1, 5'd1, 5'd2, 12'h002),
          32'h2000, 32'h9999CAFE,
          1, 32'h2002, 32'hCAFE0000, 4'hC);
    issue(enc(3'd0, 5'd1, 5'd2, 12'h001),
          32'h2000, 32'h00000055,
          1, 32'h2001, 32'h00005500, 4'h2);
    issue(enc(3'd2, 5'd1, 5'd2, 12'hFFC),
          32'h2000, 32'h01020304,
          1, 32'h1FFC, 32'h01020304, 4'hF);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_addr", mem_addr, 32'h2000);
    chk("hold_be", 32'(mem_be), 32'hF);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    chk("pop_count", 32'(count), 32'd3);
    issue(enc(3'd2, 5'd1, 5'd2, 12'h008),
          32'hFFFFFFFC, 32'hA5A5A5A5,
          1, 32'h00000004, 32'hA5A5A5A5, 4'hF);
    chk("pushpop_count1", 32'(count), 32'd3);
    issue(enc(3'd2, 5'd1, 5'd2, 12'h000),
          32'h3000, 32'h00000000,
          1, 32'h3000, 32'h00000000, 4'hF);
    chk("pushpop_count2", 32'(count), 32'd3);
    wait_empty("drain2");

    // Reserved funct3 values
    mem_req_ready = 1'b0;
    issue(enc(3'd5, 5'd1, 5'd2, 12'h000),
          32'h4000, 32'h1, 0, '0, '0, '0);
    chk("ill5_pulse", 32'(illegal_store), 32'd1);
    chk("ill5_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    chk("ill5_clear", 32'(illegal_store), 32'd0);
    issue(enc(3'd3, 5'd1, 5'd2, 12'h000),
          32'h4000, 32'h1, 0, '0, '0, '0);
    chk("ill3_pulse", 32'(illegal_store), 32'd1);
    chk("ill3_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    chk("ill3_clear", 32'(illegal_store), 32'd0);

    // Misaligned stores
    mem_req_ready = 1'b1;
`ifdef STORE_MISALIGN_CHK_EN
    issue(enc(3'd1, 5'd1, 5'd2, 12'h001),
          32'h2000, 32'h0000BEEF, 0, '0, '0, '0);
    chk("mis_pulse", 32'(misalign_fault), 32'd1);
    chk("mis_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    chk("mis_clear", 32'(misalign_fault), 32'd0);
`else
    issue(enc(3'd1, 5'd1, 5'd2, 12'h001),
          32'h2000, 32'h0000BEEF,
          1, 32'h2001, 32'h00BEEF00, 4'h6);
    chk("mis_nofault", 32'(misalign_fault), 32'd0);
    issue(enc(3'd2, 5'd1, 5'd2, 12'h003),
          32'h2000, 32'h11223344,
          1, 32'h2003, 32'h44000000, 4'h8);
`endif
    wait_empty("drain3");

    // Flush with an un-acked head and a same-cycle push
    mem_req_ready = 1'b0;
    issue(enc(3'd2, 5'd1, 5'd2, 12'h000),
          32'h5000, 32'h1, 0, '0, '0, '0);
    issue(enc(3'd2, 5'd1, 5'd2, 12'h004),
          32'h5000, 32'h2, 0, '0, '0, '0);
    issue(enc(3'd2, 5'd1, 5'd2, 12'h008),
          32'h5000, 32'h3, 0, '0, '0, '0);
    chk("preflush_count", 32'(count), 32'd3);
    ins = enc(3'd2, 5'd1, 5'd2, 12'h00C);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(mem_req_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a drain
    issue(enc(3'd2, 5'd1, 5'd2, 12'h000),
          32'h6000, 32'hAAAA0001,
          1, 32'h6000, 32'hAAAA0001, 4'hF);
    issue(enc(3'd2, 5'd1, 5'd2, 12'h004),
          32'h6000, 32'hAAAA0002,
          1, 32'h6004, 32'hAAAA0002, 4'hF);
    issue(enc(3'd2, 5'd1, 5'd2, 12'h008),
          32'h6000, 32'hAAAA0003, 0, '0, '0, '0);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    sb.delete();
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(mem_req_valid), 32'd0);
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
